// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_pkg
// Description : Shared pipeline package for all stage registers. Holds the
//               occupancy state encoding, default payload/control widths and
//               a helper that maps a state to its held-entry count.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_reg_pkg;

    localparam int DEFAULT_DATA_W = 96;
    localparam int DEFAULT_CTRL_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY = 2'd0;  // nothing held
    localparam state_t ST_MAIN  = 2'd1;  // main register holds one entry
    localparam state_t ST_SKID  = 2'd2;  // main and skid both hold entries

    // Number of entries held in a given state.
    function automatic logic [1:0] occupancy_of(input state_t st);
        case (st)
            ST_MAIN: occupancy_of = 2'd1;
            ST_SKID: occupancy_of = 2'd2;
            default: occupancy_of = 2'd0;
        endcase
    endfunction

endpackage : pipe_stage_reg_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Handshake bundle around one pipeline stage register.
//               Upstream side: in_valid/in_ready/in_data/in_ctrl plus flush.
//               Downstream side: out_valid/out_ready/out_data/out_ctrl plus
//               the occupancy status.
// Modports    : master - the environment (upstream producer, downstream
//                        consumer and flush source) driving the stage
//               slave  - the stage register itself
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CTRL_W = DEFAULT_CTRL_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_data, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );

endinterface : pipe_stage_reg_if
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Two-entry skid-buffered pipeline stage register. Payload is
//               carried unmodified; the control bundle is zeroed whenever the
//               slot is empty so a bubble behaves as a NOP. flush kills all
//               held and incoming instructions.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-low reset
//               bus   - pipe_stage_reg_if.slave handshake bundle
//                       (in_valid/in_ready/in_data/in_ctrl, flush,
//                        out_valid/out_ready/out_data/out_ctrl, occupancy)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CTRL_W = DEFAULT_CTRL_W
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pipe_stage_reg_if.slave   bus
);

    state_t            state;
    state_t            next_state;
    logic              in_ready_q;
    logic [1:0]        occupancy_q;

    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic              in_xfer;
    logic              out_xfer;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    logic              out_valid_c;
    logic [CTRL_W-1:0] out_ctrl_c;

    // in_ready is a flop, so acceptance never looks at out_ready.
    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = (state != ST_EMPTY) & bus.out_ready;

    // ------------------------------------------------------------------
    // State register (plus the registered status outputs derived from
    // the next state, so they line up with the state they describe).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state       <= next_state;
            in_ready_q  <= (next_state != ST_SKID);
            occupancy_q <= occupancy_of(next_state);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and load-select logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    next_state   = ST_MAIN;
                    load_main_in = 1'b1;
                end
            end
            ST_MAIN: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    next_state = ST_SKID;
                    load_skid  = 1'b1;
                end else if (out_xfer) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_xfer) begin
                    next_state     = ST_MAIN;
                    load_main_skid = 1'b1;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
        // flush overrides everything; any output transfer this cycle has
        // already been taken by the consumer, the incoming word is dropped.
        if (bus.flush) begin
            next_state     = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Main / skid storage. Data may go stale when emptied; control is
    // cleared so that a bubble can never carry side-effect bits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= bus.in_data;
                main_ctrl <= bus.in_ctrl;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end else if (next_state == ST_EMPTY) begin
                main_ctrl <= '0;
            end

            if (load_skid) begin
                skid_data <= bus.in_data;
                skid_ctrl <= bus.in_ctrl;
            end else if (bus.flush) begin
                skid_ctrl <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode: outputs come only from registers, never from inputs.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_c = (state != ST_EMPTY);
        out_ctrl_c  = out_valid_c ? main_ctrl : '0;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = main_data;
    assign bus.out_ctrl  = out_ctrl_c;
    assign bus.occupancy = occupancy_q;

endmodule : pipe_stage_reg
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, width of the payload (PC, ALU result, store data) carried unmodified.
REQ-002 SHALL have parameter CTRL_W, default 8, width of the control bundle (branch, memread, memreg, memwrite, regwrite, zero, rd spare bits) zeroed on bubble/flush.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset; the block is in reset while reset=0.
REQ-005 SHALL have port in_valid, input, 1, upstream stage holds a valid instruction.
REQ-006 SHALL have port in_ready, output, 1, block accepts input this cycle.
REQ-007 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-008 SHALL have port in_ctrl, input, CTRL_W, upstream control bundle.
REQ-009 SHALL have port flush, input, 1, kill all held and incoming instructions (branch taken, interrupt entry).
REQ-010 SHALL have port out_valid, output, 1, downstream slot holds a valid instruction.
REQ-011 SHALL have port out_ready, input, 1, downstream stage consumes this cycle.
REQ-012 SHALL have port out_data, output, DATA_W, held payload.
REQ-013 SHALL have port out_ctrl, output, CTRL_W, held control bundle.
REQ-014 SHALL have port occupancy, output, 2, number of held entries (0..2).

Function
REQ-015 Input transfer SHALL occur when in_valid=1 and in_ready=1; output transfer when out_valid=1 and out_ready=1.
REQ-016 Storage SHALL be a main register and a skid register; state machine EMPTY (0 held), MAIN (1 held), SKID (2 held).
REQ-017 EMPTY: input transfer -> MAIN, main loaded; else stay.
REQ-018 MAIN: input and output transfer -> MAIN, main reloaded; input only -> SKID, skid loaded; output only -> EMPTY; neither -> stay.
REQ-019 SKID: output transfer -> MAIN, main loaded from skid; else stay; no input accepted.
REQ-020 in_ready SHALL be a registered output equal to 1 in EMPTY and MAIN, 0 in SKID; it never depends combinationally on out_ready.
REQ-021 out_valid SHALL be 1 in MAIN and SKID, 0 in EMPTY; out_data/out_ctrl SHALL always present the main register.
REQ-022 Latency SHALL be 1 cycle from input transfer to out_valid in EMPTY; sustained throughput 1 transfer per cycle with out_ready=1.
REQ-023 Ordering SHALL be strict FIFO; no entry dropped or duplicated except by flush.
REQ-024 out_ctrl SHALL read all-zero whenever out_valid=0 (bubble equals NOP, no memory or register-file side effects).
REQ-025 flush=1 SHALL take priority over all transfers: next state EMPTY, main and skid ctrl cleared to zero, same-cycle input discarded, data registers may hold stale values.
REQ-026 After flush, in_ready SHALL be 1 in the following cycle; an output transfer in the flush cycle still counts as consumed.
REQ-027 occupancy SHALL equal 0/1/2 for EMPTY/MAIN/SKID, registered.

Reset
REQ-028 While reset=0: state EMPTY, in_ready=1... SHALL be 0 during reset and 1 from the first clk edge after release; out_valid=0, out_data=0, out_ctrl=0, occupancy=0, skid register=0.
REQ-029 Reset asserted mid-operation SHALL clear all state asynchronously without waiting for clk; held entries are lost.

Structure
REQ-030 State encoding (EMPTY=0, MAIN=1, SKID=2) and default widths SHALL live in the shared pipeline package used by all stage registers.
REQ-031 Block SHALL be flat, no sub-module; instantiated once per IF/ID, ID/EX, EX/MEM, MEM/WB boundary with differing DATA_W/CTRL_W.

Verification
REQ-032 Reset release, in_valid=1 data=0x11 ctrl=0x05, out_ready=1 -> out_valid=1, out_data=0x11, out_ctrl=0x05 one cycle later; occupancy=1.
REQ-033 Stream 0x01..0x08 back-to-back, out_ready=1 -> outputs 0x01..0x08 on consecutive cycles, in_ready stays 1.
REQ-034 out_ready=0 while feeding 0x21, 0x22, 0x23 -> 0x21 in main, 0x22 in skid, in_ready=0, 0x23 held upstream; out_ready=1 -> 0x21, 0x22, 0x23 in order.
REQ-035 In SKID, pulse flush with in_valid=1 data=0x33 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; 0x33 never appears.
REQ-036 Assert reset=0 asynchronously between edges while occupancy=2 -> out_valid, out_ctrl, occupancy read 0 immediately.
REQ-037 Random valid/ready/flush, 10k cycles -> scoreboard shows in-order delivery and out_ctrl=0 whenever out_valid=0.
